// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
// Bytes enter on a one-cycle write strobe. They are serialised LSB first on TXD
// at CLK_DIV clocks per bit, and back-to-back frames leave no idle gap.
module uart_tx_fifo #(
  parameter int unsigned CLK_DIV    = 13021,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  output logic       full,
  output logic       busy,
  output logic       TXD
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] CNT_MAX = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_n;
  logic          push, pop, fifo_ne;

  state_t        state, state_n;
  logic [BW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          period_end;
  logic          txd_n, busy_n, full_n;

  // A write is judged against the registered full flag, so it is refused
  // while full even if a pop happens in the same cycle.
  assign push       = wr_en && !full;
  assign fifo_ne    = (count != '0);
  assign period_end = (cnt == CNT_MAX);

  // FIFO storage: the payload needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
    end
  end

  // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel.
  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  // Framing FSM and baud counter registers, together with the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      TXD     <= 1'b1;
      busy    <= 1'b0;
      full    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      TXD     <= txd_n;
      busy    <= busy_n;
      full    <= full_n;
    end
  end

  // Next-state logic. The outputs are derived from the next state so that TXD
  // changes on the same edge as the state and comes straight from a flop.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + BW'(1);
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (fifo_ne) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
        end
      end
      START: begin
        if (period_end) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (period_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (period_end) begin
          cnt_n = '0;
          if (fifo_ne) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    unique case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[bit_n];
      default: txd_n = 1'b1;
    endcase

    busy_n = (state_n != IDLE) || (count_n != '0);
    full_n = (count_n == CW'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo at CLK_DIV=16, FIFO_DEPTH=4.
// A mid-bit sampling receiver captures every frame on TXD and compares it with
// the frame that was queued when the byte was written.
module tb_uart_tx_fifo;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       wr_en = 1'b0;
  logic       full, busy, txd;

  int total = 0;
  int bad   = 0;

  uart_tx_fifo #(.CLK_DIV(D), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_in),
    .wr_en  (wr_en),
    .full   (full),
    .busy   (busy),
    .TXD    (txd)
  );

  always #5 clk = ~clk;

  // Compare one value and keep the counts.
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected 10-bit frames (bit 0 = start bit, bit 9 = stop bit).
  logic [9:0] exp_q[$];

  // Receiver: it finds a start bit and samples each bit at its midpoint.
  // For each frame it then emits a one-cycle rx_valid and checks the frame.
  logic       mon_clr = 1'b0;
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [9:0] mon_frame = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = '0;

  always @(negedge clk) begin
    rx_valid = 1'b0;
    if (mon_clr || rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (txd == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_frame  = '0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % D == D / 2) mon_frame[4'(mon_cnt / D)] = txd;
      if (mon_cnt == 9 * D + D / 2) begin
        mon_active = 1'b0;
        rx_byte    = mon_frame[8:1];
        rx_valid   = 1'b1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame_unexpected: got %0h, expected none", mon_frame);
        end else begin
          check("frame", int'(mon_frame), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Present one byte on the next edge; the caller drops wr_en afterwards.
  task automatic drive(input logic [7:0] b, input logic accept, input logic [9:0] fr);
    data_in = b;
    wr_en   = 1'b1;
    if (accept) exp_q.push_back(fr);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy !== 1'b0 || mon_active || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", int'(n < budget), 1);
    skip(4);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t       vecs[4];
  logic [9:0] ovf_fr[5];
  int         glitches;

  initial begin
    vecs[0] = '{data: 8'h00, frame: 10'b1000000000};
    vecs[1] = '{data: 8'hFF, frame: 10'b1111111110};
    vecs[2] = '{data: 8'h5A, frame: 10'b1010110100};
    vecs[3] = '{data: 8'h81, frame: 10'b1100000010};
    ovf_fr  = '{10'b1000000010, 10'b1000000100, 10'b1000000110,
                10'b1000001000, 10'b1000001010};

    // Reset values, while reset is still asserted.
    skip(3);
    check("rst_txd", int'(txd), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_full", int'(full), 0);
    rst = 1'b0;
    skip(3);

    // Single byte 0x55: one cycle of latency, then exact bit edges and busy fall.
    drive(8'h55, 1'b1, 10'b1010101010);      // edge N; now at N+0.5
    wr_en = 1'b0;
    check("lat_txd_still_high", int'(txd), 1);
    check("lat_busy_rise", int'(busy), 1);
    skip(1);                                  // N+1.5
    check("start_bit_low", int'(txd), 0);
    skip(15);                                 // N+16.5
    check("start_bit_end", int'(txd), 0);
    skip(1);                                  // N+17.5
    check("bit0_is_1", int'(txd), 1);
    skip(16);                                 // N+33.5
    check("bit1_is_0", int'(txd), 0);
    skip(127);                                // N+160.5
    check("busy_before_end", int'(busy), 1);
    check("stop_bit_high", int'(txd), 1);
    skip(1);                                  // N+161.5
    check("busy_fall_160", int'(busy), 0);
    wait_idle(400);

    // Back-to-back frames: 0xA3 then 0x0F on consecutive cycles.
    drive(8'hA3, 1'b1, 10'b1101000110);
    drive(8'h0F, 1'b1, 10'b1000011110);      // now at N+1.5
    wr_en = 1'b0;
    check("b2b_start1", int'(txd), 0);
    skip(159);                                // N+160.5
    check("b2b_stop1", int'(txd), 1);
    skip(1);                                  // N+161.5
    check("b2b_start2_no_gap", int'(txd), 0);
    skip(159);                                // N+320.5
    check("b2b_busy_320", int'(busy), 1);
    skip(1);                                  // N+321.5
    check("b2b_busy_fall", int'(busy), 0);
    wait_idle(400);

    // Table of bytes written on consecutive cycles; each frame is checked by the receiver.
    for (int i = 0; i < 4; i++) drive(vecs[i].data, 1'b1, vecs[i].frame);
    wr_en = 1'b0;
    wait_idle(800);
    check("table_busy_low", int'(busy), 0);

    // Overflow: six writes at idle. The fifth sets full and the sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      drive(8'(i + 1), i < 5, (i < 5) ? ovf_fr[i] : 10'b0);
      check($sformatf("ovf_full_after_wr%0d", i + 1), int'(full), int'(i >= 4));
    end
    wr_en = 1'b0;                             // at N+5.5
    skip(155);                                // N+160.5
    check("ovf_full_before_pop2", int'(full), 1);
    skip(1);                                  // N+161.5
    check("ovf_full_clear_pop2", int'(full), 0);
    wait_idle(1200);

    // Reset during data bit 3 of 0xF0 while two more bytes are queued.
    drive(8'hF0, 1'b1, 10'b1111100000);
    drive(8'h11, 1'b1, 10'b1000100010);
    drive(8'h22, 1'b1, 10'b1001000100);      // now at N+2.5
    wr_en = 1'b0;
    skip(70);                                 // N+72.5, inside data bit 3
    check("pre_rst_bit3_low", int'(txd), 0);
    check("pre_rst_full", int'(full), 0);
    mon_clr = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("midrst_txd", int'(txd), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_full", int'(full), 0);
    exp_q.delete();
    skip(2);
    rst = 1'b0;
    mon_clr = 1'b0;
    glitches = 0;
    for (int i = 0; i < 40 * D; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) glitches++;
    end
    check("post_rst_line_quiet", glitches, 0);
    drive(8'h3C, 1'b1, 10'b1001111000);
    wr_en = 1'b0;
    wait_idle(400);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
